// File: rtl/fir_tap_mac_pkg.sv
// fir_pkg: shared widths, FSM state encoding and the tap product helper
// for the sequential FIR tap engine.
package fir_pkg;

  localparam int SAMPLE_W = 8;
  localparam int COEF_W   = 8;
  localparam int ACC_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Full-width unsigned 8x8 product; never truncated before accumulation.
  function automatic logic [ACC_W-1:0] tap_product(
    input logic [SAMPLE_W-1:0] x,
    input logic [COEF_W-1:0]   c
  );
    return ACC_W'(x) * ACC_W'(c);
  endfunction

endpackage

// File: rtl/fir_tap_mac_if.sv
// Sample-in / result-out handshake bundle of the FIR tap engine.
// master = producer/consumer side, slave = the engine.
interface fir_tap_mac_if;
  import fir_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir_tap_mac_brentkung16.sv
// brentkung16: 16-bit Brent-Kung parallel-prefix adder, no carry-in,
// carry-out discarded (sum wraps modulo 2^16).
module brentkung16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  // Up-sweep builds group generate/propagate on power-of-two spans, the
  // down-sweep fills in the remaining prefix positions.
  function automatic logic [15:0] bk_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p;
    logic [15:0] gg;
    logic [15:0] pp;
    p  = x ^ y;
    gg = x & y;
    pp = p;
    for (int l = 0; l < 4; l++) begin
      for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    for (int l = 2; l >= 0; l--) begin
      for (int i = 3 * (1 << l) - 1; i < 16; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
    // Carry into bit i is the prefix generate of bits [i-1:0].
    return {p[15:1] ^ gg[14:0], p[0]};
  endfunction

  // Combinational sum.
  always_comb begin
    sum = bk_add(a, b);
  end

endmodule

// File: rtl/fir_tap_mac.sv
// fir_tap_mac: sequential direct-form FIR, one tap per clock through a
// single 8x8 multiplier and the Brent-Kung adder.
// Optional build macro: COEF_WR_EN (run-time writable coefficients).
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter int                      TAPS = 4,
  parameter logic [TAPS*COEF_W-1:0]  COEF = 32'h04030201
) (
  input  logic                clk,
  input  logic                rst,
  fir_tap_mac_if.slave        bus
`ifdef COEF_WR_EN
  ,
  input  logic                coef_we,
  input  logic [3:0]          coef_addr,
  input  logic [COEF_W-1:0]   coef_wdata
`endif
);

  localparam int K_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_e              state_q;
  state_e              state_d;
  logic [SAMPLE_W-1:0] line_q [TAPS];
  logic [COEF_W-1:0]   coef_s [TAPS];
  logic [ACC_W-1:0]    acc_q;
  logic [K_W-1:0]      k_q;
  logic                out_valid_q;
  logic [ACC_W-1:0]    out_data_q;

  logic                accept_s;
  logic                last_s;
  logic [ACC_W-1:0]    prod_s;
  logic [ACC_W-1:0]    sum_s;

  assign accept_s = (state_q == IDLE) && bus.in_valid;
  assign last_s   = (k_q == K_W'(TAPS - 1));

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

`ifdef COEF_WR_EN
  logic [COEF_W-1:0] coef_q [TAPS];
  logic              coef_wr_s;

  // Writes land only while idle and only to an existing tap.
  assign coef_wr_s = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < 5'(TAPS));

  // Coefficient register file, restored to the build-time set on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= COEF[i*COEF_W +: COEF_W];
    end else if (coef_wr_s) begin
      coef_q[coef_addr[K_W-1:0]] <= coef_wdata;
    end else begin
      coef_q <= coef_q;
    end
  end

  // Present the live coefficient set to the tap mux.
  always_comb begin
    for (int i = 0; i < TAPS; i++) coef_s[i] = coef_q[i];
  end
`else
  // Constant coefficient set unpacked from the parameter.
  always_comb begin
    for (int i = 0; i < TAPS; i++) coef_s[i] = COEF[i*COEF_W +: COEF_W];
  end
`endif

  // Tap mux and product for the current k.
  always_comb begin
    prod_s = tap_product(line_q[k_q], coef_s[k_q]);
  end

  brentkung16 u_add (
    .a   (acc_q),
    .b   (prod_s),
    .sum (sum_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: accept, TAPS MAC cycles, hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = MAC;
        else          state_d = IDLE;
      end
      MAC: begin
        if (last_s) state_d = OUT;
        else        state_d = MAC;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
        else               state_d = OUT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: delay line shift on accept, accumulation, result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) line_q[i] <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            line_q[0] <= bus.in_data;
            for (int i = 1; i < TAPS; i++) line_q[i] <= line_q[i-1];
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        MAC: begin
          acc_q <= sum_s;
          k_q   <= k_q + K_W'(1);
          // The final sum goes straight to the output register so the
          // result is visible the cycle OUT is entered.
          if (last_s) begin
            out_data_q  <= sum_s;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
